// File: rtl/sysid_regs.sv
// rtl/sysid_regs.sv - Avalon-MM system ID / housekeeping slave with scratch bank, cycle snapshot and uptime.
// Optional uptime counter and 1 Hz tick are built when SYSID_UPTIME_EN is defined.
module sysid_regs #(
    parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned NUM_USER  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        tick_1hz
);

    localparam logic [7:0] NUM_USER_B = 8'(NUM_USER);
`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    logic [63:0] cycle_cnt;
    logic [63:0] snapshot;
    logic [31:0] scratch [0:7];
    logic [31:0] uptime_word;
    logic [31:0] rd_word;
    logic        ctrl_wr;
    logic        user_hit;
    logic [2:0]  user_idx;

    assign ctrl_wr  = write && (address == 4'd3);
    assign user_idx = address[2:0];
    assign user_hit = address[3] && (32'(user_idx) < NUM_USER);

    // Both snapshot halves come from one 64-bit capture, so LO/HI reads are coherent.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (ctrl_wr && writedata[0]) begin
                snapshot <= cycle_cnt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                scratch[i] <= '0;
            end
        end else if (write && user_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[user_idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

`ifdef SYSID_UPTIME_EN
    localparam logic [31:0] PRESC_TERM = 32'(CLK_HZ - 1);

    logic [31:0] prescaler;
    logic [31:0] uptime;

    // A clear beats a coincident terminal count and swallows that tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            uptime    <= '0;
            tick_1hz  <= 1'b0;
        end else if (ctrl_wr && writedata[1]) begin
            prescaler <= '0;
            uptime    <= '0;
            tick_1hz  <= 1'b0;
        end else if (prescaler == PRESC_TERM) begin
            prescaler <= '0;
            uptime    <= uptime + 32'd1;
            tick_1hz  <= 1'b1;
        end else begin
            prescaler <= prescaler + 32'd1;
            tick_1hz  <= 1'b0;
        end
    end

    assign uptime_word = uptime;
`else
    assign uptime_word = '0;
    assign tick_1hz    = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        case (address)
            4'd0:    rd_word = SYSTEM_ID;
            4'd1:    rd_word = TIMESTAMP;
            4'd2:    rd_word = {23'd0, UPTIME_PRESENT, NUM_USER_B};
            4'd4:    rd_word = snapshot[31:0];
            4'd5:    rd_word = snapshot[63:32];
            4'd6:    rd_word = uptime_word;
            default: begin
                if (user_hit) begin
                    rd_word = scratch[user_idx];
                end
            end
        endcase
    end

    // A read colliding with a write is dropped; readdata holds its last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read && !write;
            if (read && !write) begin
                readdata <= rd_word;
            end
        end
    end

endmodule
